alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//   Shares one 64-bit Y86-64 ALU (ADD/SUB/AND/XOR, with the AND/XOR bitwise units) between two requesters.
//   Requester 0 is the execute-stage OPq path; requester 1 is address/stack-pointer arithmetic.
//   Arbitration is round-robin with a valid/ready request and response handshake.
//   Result and condition codes (ZF, SF, OF) are registered and held until the consumer accepts them.
// PARAMETERS
//   W        64   operand/result width; W >= 2
// PORTS
//   clk          in   1     rising-edge clock
//   rst          in   1     asynchronous reset, active-high
//   req_valid    in   2     per-requester request; held with operands until accepted
//   req_ready    out  2     per-requester grant; a request is accepted on an edge with valid&ready
//   req0_fun     in   2     requester 0 op: 0=ADD 1=SUB 2=AND 3=XOR (Y86 ifun)
//   req0_a       in   W     requester 0 operand A (valA)
//   req0_b       in   W     requester 0 operand B (valB)
//   req1_fun     in   2     requester 1 op, same encoding
//   req1_a       in   W     requester 1 operand A
//   req1_b       in   W     requester 1 operand B
//   rsp_valid    out  1     result available
//   rsp_ready    in   1     consumer accepts result on an edge with rsp_valid&rsp_ready
//   rsp_id       out  1     requester that owns the result
//   rsp_data     out  W     ALU result
//   rsp_cc       out  3     {ZF,SF,OF}
// BEHAVIOUR
//   Reset (async, active-high) -> state IDLE, rr_last=1 (requester 0 wins first).
//     All outputs are 0 during and immediately after reset. Reset mid-EXEC/RESP aborts the op; no response is produced.
//   FSM: IDLE -> EXEC on an accept edge; EXEC -> RESP unconditionally; RESP -> IDLE on rsp_valid&rsp_ready.
//   req_ready is combinational and nonzero only in IDLE. It is one-hot or 0 and never asserted for a requester whose valid is low.
//     Only one requester valid: that requester is granted.
//     Both valid: grant ~rr_last. rr_last updates to the granted id on the accept edge.
//   Accept edge: fun, a, b and id are latched. req operands/fun may change afterwards without effect.
//   EXEC edge: result and cc are latched. rsp_valid rises 2 edges after the accept edge.
//   RESP: rsp_valid=1. rsp_id, rsp_data and rsp_cc are stable until the handshake; no new accept is allowed.
//   After the handshake rsp_valid=0 and rsp_data/rsp_cc/rsp_id hold their last values.
//   Peak throughput is 1 op per 3 cycles when rsp_ready is tied high.
//   Arithmetic is modulo 2^W, two's complement.
//     ADD: a+b.
//     SUB: b-a (Y86 subq semantics).
//     AND: a&b.
//     XOR: a^b.
//   Condition codes:
//     ZF = (result==0).
//     SF = result[W-1].
//     OF for ADD: a[W-1]==b[W-1] && r[W-1]!=a[W-1].
//     OF for SUB: a[W-1]!=b[W-1] && r[W-1]!=b[W-1].
//     OF for AND/XOR: 0.
//   A requester that drops req_valid before it is accepted is legal; it is simply not granted.
// TESTING
//   XOR: req0, a=64'hF0F0F0F0F0F0F0F4, b=64'hCCCCCCCCCCCCCCC5 -> rsp_data=64'h3C3C3C3C3C3C3C31, cc=3'b000, id=0, rsp_valid 2 edges after accept.
//   ADD overflow: req1, a=b=64'h7FFFFFFFFFFFFFFF -> rsp_data=64'hFFFFFFFFFFFFFFFE, cc=3'b011, id=1.
//   SUB zero/neg: a=b=5 -> 0, cc=3'b100; a=6, b=5 -> 64'hFFFFFFFFFFFFFFFF, cc=3'b010.
//   Fairness: both valid continuously, rsp_ready=1 -> grant order 0,1,0,1, one grant every 3 cycles.
//   Backpressure: hold rsp_ready=0 for 4 cycles in RESP -> rsp_* stable, req_ready=2'b00; release -> IDLE next edge.
//   Reset in EXEC: assert rst for 1 cycle -> rsp_valid never rises, next request is granted to requester 0.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one Y86-64 ALU (ADD/SUB/AND/XOR) between two requesters.
// Result and {ZF,SF,OF} are registered and held until the consumer accepts them.
module alu_share_arbiter #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [1:0]   req0_fun,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic [1:0]   req1_fun,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic [2:0]   rsp_cc
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    state_t       state;
    logic         rr_last;
    logic         op_id;
    logic [1:0]   op_fun;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic [1:0]   grant;
    logic [W-1:0] res;
    logic         of;
    logic [W-1:0] sum;
    logic [W-1:0] dif;
    logic [2:0]   cc;

    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = rst ? 2'b00 : grant;

    // SUB is b-a to match Y86 subq
    assign sum = op_a + op_b;
    assign dif = op_b - op_a;

    always_comb begin
        res = sum;
        of  = 1'b0;
        case (op_fun)
            2'd0: begin
                res = sum;
                of  = (op_a[W-1] == op_b[W-1]) && (sum[W-1] != op_a[W-1]);
            end
            2'd1: begin
                res = dif;
                of  = (op_a[W-1] != op_b[W-1]) && (dif[W-1] != op_b[W-1]);
            end
            2'd2: res = op_a & op_b;
            default: res = op_a ^ op_b;
        endcase
    end

    assign cc = {(res == '0), res[W-1], of};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_last   <= 1'b1;
            op_id     <= 1'b0;
            op_fun    <= 2'd0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_cc    <= 3'b000;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        op_id   <= grant[1];
                        rr_last <= grant[1];
                        op_fun  <= grant[1] ? req1_fun : req0_fun;
                        op_a    <= grant[1] ? req1_a : req0_a;
                        op_b    <= grant[1] ? req1_b : req0_b;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data  <= res;
                    rsp_cc    <= cc;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: ALU ops, flags, arbitration,
// backpressure and reset abort, all with hand-computed expectations.
module tb_alu_share_arbiter;

    localparam int W = 64;

    logic         clk;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [1:0]   req0_fun;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic [1:0]   req1_fun;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_data;
    logic [2:0]   rsp_cc;

    int errors = 0;
    int checks = 0;

    alu_share_arbiter #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req0_fun  (req0_fun),
        .req0_a    (req0_a),
        .req0_b    (req0_b),
        .req1_fun  (req1_fun),
        .req1_a    (req1_a),
        .req1_b    (req1_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_cc    (rsp_cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op from requester id; returns in RESP (posedge+1) with rsp_ready low.
    task automatic run_op(input logic id, input logic [1:0] fun,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic rv_mid);
        bit ok;
        ok = 0;
        rv_mid = 1'bx;
        if (id) begin
            req1_fun = fun; req1_a = a; req1_b = b;
        end else begin
            req0_fun = fun; req0_a = a; req0_b = b;
        end
        req_valid[id] = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL grant_timeout id=%0d req_ready=%b required grant", id, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
        rv_mid = rsp_valid;
        if (id) begin
            req1_fun = 2'($urandom); req1_a = {$urandom, $urandom}; req1_b = {$urandom, $urandom};
        end else begin
            req0_fun = 2'($urandom); req0_a = {$urandom, $urandom}; req0_b = {$urandom, $urandom};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL handshake_clear rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        req0_fun = 0; req0_a = 0; req0_b = 0;
        req1_fun = 0; req1_a = 0; req1_b = 0;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 2'b01;
        #1;
        checks++;
        if (req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got=%b required 00", req_ready);
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_cc, req_ready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs v=%b id=%b d=%h cc=%b rdy=%b required all 0",
                     rsp_valid, rsp_id, rsp_data, rsp_cc, req_ready);
        end
    endtask

    task automatic test_xor();
        logic rv_mid;
        run_op(1'b0, 2'd3, 64'hF0F0F0F0F0F0F0F4, 64'hCCCCCCCCCCCCCCC5, rv_mid);
        checks++;
        if (rv_mid !== 1'b0) begin
            errors++;
            $display("FAIL xor_early_valid got=%b required 0 one edge after accept", rv_mid);
        end
        checks++;
        if ({rsp_valid, rsp_id, rsp_cc, rsp_data} !== {1'b1, 1'b0, 3'b000, 64'h3C3C3C3C3C3C3C31}) begin
            errors++;
            $display("FAIL xor_result v=%b id=%b cc=%b d=%h required 1 0 000 3c3c3c3c3c3c3c31",
                     rsp_valid, rsp_id, rsp_cc, rsp_data);
        end
        handshake();
        checks++;
        if (rsp_data !== 64'h3C3C3C3C3C3C3C31 || rsp_cc !== 3'b000) begin
            errors++;
            $display("FAIL xor_hold d=%h cc=%b required held result", rsp_data, rsp_cc);
        end
    endtask

    task automatic test_add_ovf();
        logic rv_mid;
        run_op(1'b1, 2'd0, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, rv_mid);
        checks++;
        if ({rsp_valid, rsp_id, rsp_cc, rsp_data} !== {1'b1, 1'b1, 3'b011, 64'hFFFFFFFFFFFFFFFE}) begin
            errors++;
            $display("FAIL add_ovf v=%b id=%b cc=%b d=%h required 1 1 011 fffffffffffffffe",
                     rsp_valid, rsp_id, rsp_cc, rsp_data);
        end
        handshake();
    endtask

    task automatic test_sub();
        logic rv_mid;
        run_op(1'b0, 2'd1, 64'd5, 64'd5, rv_mid);
        checks++;
        if ({rsp_cc, rsp_data} !== {3'b100, 64'd0}) begin
            errors++;
            $display("FAIL sub_zero cc=%b d=%h required 100 0", rsp_cc, rsp_data);
        end
        handshake();
        run_op(1'b0, 2'd1, 64'd6, 64'd5, rv_mid);
        checks++;
        if ({rsp_cc, rsp_data} !== {3'b010, 64'hFFFFFFFFFFFFFFFF}) begin
            errors++;
            $display("FAIL sub_neg cc=%b d=%h required 010 ffffffffffffffff", rsp_cc, rsp_data);
        end
        handshake();
        run_op(1'b1, 2'd1, 64'd1, 64'h8000000000000000, rv_mid);
        checks++;
        if ({rsp_id, rsp_cc, rsp_data} !== {1'b1, 3'b001, 64'h7FFFFFFFFFFFFFFF}) begin
            errors++;
            $display("FAIL sub_ovf id=%b cc=%b d=%h required 1 001 7fffffffffffffff",
                     rsp_id, rsp_cc, rsp_data);
        end
        handshake();
    endtask

    task automatic test_and();
        logic rv_mid;
        run_op(1'b1, 2'd2, 64'hFF00FF00FF00FF00, 64'h8F0F0F0F0F0F0F0F, rv_mid);
        checks++;
        if ({rsp_cc, rsp_data} !== {3'b010, 64'h8F000F000F000F00}) begin
            errors++;
            $display("FAIL and_result cc=%b d=%h required 010 8f000f000f000f00", rsp_cc, rsp_data);
        end
        handshake();
    endtask

    task automatic test_backpressure();
        logic rv_mid;
        run_op(1'b1, 2'd0, 64'd3, 64'd4, rv_mid);
        req0_fun = 2'd0; req0_a = 64'd9; req0_b = 64'd9;
        req1_fun = 2'd0; req1_a = 64'd8; req1_b = 64'd8;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_cc, rsp_data, req_ready} !== {1'b1, 1'b1, 3'b000, 64'd7, 2'b00}) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d v=%b id=%b cc=%b d=%h rdy=%b required 1 1 000 7 00",
                         i, rsp_valid, rsp_id, rsp_cc, rsp_data, req_ready);
            end
            @(posedge clk);
        end
        #1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if ({rsp_valid, req_ready} !== {1'b0, 2'b01}) begin
            errors++;
            $display("FAIL bp_release v=%b rdy=%b required 0 01", rsp_valid, req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_reset_exec();
        bit seen;
        req0_fun = 2'd0; req0_a = 64'd1; req0_b = 64'd1;
        req_valid = 2'b01;
        @(negedge clk);
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_exec_grant rdy=%b required 01", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (rsp_valid !== 1'b0) seen = 1;
            @(posedge clk);
            #1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_exec_no_rsp rsp_valid rose=1 required 0");
        end
        req_valid = 2'b11;
        #1;
        checks++;
        if (req_ready !== 2'b01) begin
            errors++;
            $display("FAIL rst_exec_rr rdy=%b required 01", req_ready);
        end
        req_valid = 2'b00;
    endtask

    task automatic test_fairness();
        int n;
        logic gid [8];
        int gcyc [8];
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rsp_ready = 1'b1;
        req0_fun = 2'd0; req0_a = 64'd1; req0_b = 64'd2;
        req1_fun = 2'd3; req1_a = 64'd1; req1_b = 64'd2;
        req_valid = 2'b11;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00 && n < 8) begin
                gid[n] = req_ready[1];
                gcyc[n] = i;
                n++;
            end
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL fair_count got=%0d required 4", n);
        end
        for (int i = 0; i < 4 && i < n; i++) begin
            checks++;
            if (gid[i] !== i[0] || gcyc[i] != 3 * i) begin
                errors++;
                $display("FAIL fair_grant k=%0d id=%b cyc=%0d required id=%0d cyc=%0d",
                         i, gid[i], gcyc[i], i % 2, 3 * i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_xor();
        test_add_ovf();
        test_sub();
        test_and();
        test_backpressure();
        test_reset_exec();
        test_fairness();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
